// File: rtl/imm_ext_pipe_if.sv
// Decode-to-execute immediate bundle: upstream request side plus
// downstream presentation side of the imm_ext_pipe stage.
interface imm_ext_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:7]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Registered immediate extension between decode and execute.
// Optional skid entry keeps out_ready off the in_ready path.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter bit SKID  = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  imm_ext_pipe_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  logic [31:7] ins;
  ent_t        new_e;
  ent_t        m_q, m_d;
  ent_t        k_q, k_d;
  logic        m_vld_q, m_vld_d;
  logic        k_vld_q, k_vld_d;
  logic        rdy, acc, dlv;

  assign ins = bus.in_instr;

  always_comb begin
    new_e.imm = '0;
    new_e.tag = bus.in_tag;
    new_e.ill = 1'b0;
    unique case (bus.in_imm_src)
      3'b000: new_e.imm = XLEN'($signed(ins[31:20]));
      3'b001: new_e.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      3'b010: new_e.imm = XLEN'($signed({ins[31], ins[7],
                                         ins[30:25], ins[11:8],
                                         1'b0}));
      3'b011: new_e.imm = XLEN'($signed({ins[31], ins[19:12],
                                         ins[20], ins[30:21],
                                         1'b0}));
      3'b100: new_e.imm = XLEN'($signed({ins[31:12], 12'b0}));
      3'b101: new_e.imm = XLEN'(ins[19:15]);
      3'b110: new_e.imm = XLEN'({(XLEN == 64) ? ins[25] : 1'b0,
                                 ins[24:20]});
      default: new_e.ill = 1'b1;
    endcase
  end

  // Skid mode looks only at the registered K valid.
  assign rdy = SKID ? !k_vld_q : (!m_vld_q | bus.out_ready);
  assign acc = bus.in_valid & rdy;
  assign dlv = m_vld_q & bus.out_ready;

  always_comb begin
    m_vld_d = m_vld_q;
    m_d     = m_q;
    k_vld_d = k_vld_q;
    k_d     = k_q;
    if (dlv) begin
      m_vld_d = k_vld_q;
      m_d     = k_q;
      k_vld_d = 1'b0;
    end
    if (acc) begin
      if (!m_vld_d) begin
        m_vld_d = 1'b1;
        m_d     = new_e;
      end else begin
        k_vld_d = 1'b1;
        k_d     = new_e;
      end
    end
    if (flush) begin
      m_vld_d = 1'b0;
      k_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      k_vld_q <= k_vld_d;
      m_q     <= m_d;
      k_q     <= k_d;
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = m_vld_q;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_tag     = m_q.tag;
  assign bus.out_illegal = m_q.ill;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three configurations on a shared stimulus,
// each checked against a queue-based occupancy/extension model.
module tb_imm_ext_pipe;
  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  imm_ext_pipe_if #(.XLEN(32), .TAG_W(5)) i0 ();
  imm_ext_pipe_if #(.XLEN(64), .TAG_W(5)) i1 ();
  imm_ext_pipe_if #(.XLEN(32), .TAG_W(5)) i2 ();

  imm_ext_pipe #(.XLEN(32), .TAG_W(5), .SKID(1'b1)) d0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(i0));
  imm_ext_pipe #(.XLEN(64), .TAG_W(5), .SKID(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(i1));
  imm_ext_pipe #(.XLEN(32), .TAG_W(5), .SKID(1'b0)) d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(i2));

  int    tests = 0;
  int    fails = 0;
  exp_t  q[3][$];
  bit    rdy_m[3];
  bit    out_rdy;
  string nm[3] = '{"x32s1", "x64s1", "x32s0"};
  int    xl[3] = '{32, 64, 32};
  bit    skid[3] = '{1'b1, 1'b1, 1'b0};

  function automatic longint sx(longint raw, int bits);
    return raw[bits-1] ? raw - (longint'(1) << bits) : raw;
  endfunction

  function automatic exp_t ref_ent(logic [31:0] w, logic [2:0] src,
                                   logic [4:0] tg, int xlen);
    exp_t   e;
    longint v;
    e.tag = tg;
    e.ill = 1'b0;
    v = 0;
    case (src)
      3'd0: v = sx(longint'(w[31:20]), 12);
      3'd1: v = sx(longint'({w[31:25], w[11:7]}), 12);
      3'd2: v = sx(longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      3'd3: v = sx(longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
      3'd4: v = sx(longint'(w[31:12]) * 4096, 32);
      3'd5: v = longint'(w[19:15]);
      3'd6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
      default: e.ill = 1'b1;
    endcase
    e.imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
    return e;
  endfunction

  task automatic lit(string tg, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h", tg, got, exp);
    end
  endtask

  task automatic rchk(string n, logic ov, logic ir, logic [63:0] im,
                      logic [4:0] tg, logic il);
    lit({n, ".rst_valid"}, {63'b0, ov}, 64'd0);
    lit({n, ".rst_ready"}, {63'b0, ir}, 64'd1);
    lit({n, ".rst_imm"}, im, 64'd0);
    lit({n, ".rst_tag"}, {59'b0, tg}, 64'd0);
    lit({n, ".rst_ill"}, {63'b0, il}, 64'd0);
  endtask

  task automatic rst_chk();
    rchk(nm[0], i0.out_valid, i0.in_ready, {32'b0, i0.out_imm},
         i0.out_tag, i0.out_illegal);
    rchk(nm[1], i1.out_valid, i1.in_ready, i1.out_imm,
         i1.out_tag, i1.out_illegal);
    rchk(nm[2], i2.out_valid, i2.in_ready, {32'b0, i2.out_imm},
         i2.out_tag, i2.out_illegal);
  endtask

  task automatic chk(int id, logic ov, logic ir, logic [63:0] im,
                     logic [4:0] tg, logic il);
    int n;
    bit er;
    n = q[id].size();
    er = skid[id] ? (n < 2) : (n == 0 || out_rdy);
    rdy_m[id] = er;
    lit({nm[id], ".in_ready"}, {63'b0, ir}, {63'b0, er});
    lit({nm[id], ".out_valid"}, {63'b0, ov}, {63'b0, n > 0});
    if (n > 0 && ov === 1'b1) begin
      lit({nm[id], ".imm"}, im, q[id][0].imm);
      lit({nm[id], ".tag"}, {59'b0, tg}, {59'b0, q[id][0].tag});
      lit({nm[id], ".ill"}, {63'b0, il}, {63'b0, q[id][0].ill});
    end
  endtask

  task automatic drv(bit v, logic [31:0] w, logic [2:0] src,
                     logic [4:0] tg, bit ordy, bit fl);
    i0.in_valid = v; i1.in_valid = v; i2.in_valid = v;
    i0.in_instr = w[31:7]; i1.in_instr = w[31:7]; i2.in_instr = w[31:7];
    i0.in_imm_src = src; i1.in_imm_src = src; i2.in_imm_src = src;
    i0.in_tag = tg; i1.in_tag = tg; i2.in_tag = tg;
    i0.out_ready = ordy; i1.out_ready = ordy; i2.out_ready = ordy;
    out_rdy = ordy;
    flush = fl;
  endtask

  task automatic step(bit v, logic [31:0] w, logic [2:0] src,
                      logic [4:0] tg, bit ordy, bit fl);
    drv(v, w, src, tg, ordy, fl);
    #4;
    chk(0, i0.out_valid, i0.in_ready, {32'b0, i0.out_imm},
        i0.out_tag, i0.out_illegal);
    chk(1, i1.out_valid, i1.in_ready, i1.out_imm,
        i1.out_tag, i1.out_illegal);
    chk(2, i2.out_valid, i2.in_ready, {32'b0, i2.out_imm},
        i2.out_tag, i2.out_illegal);
    @(posedge clk);
    for (int id = 0; id < 3; id++) begin
      if (ordy && q[id].size() > 0) void'(q[id].pop_front());
      if (v && rdy_m[id]) q[id].push_back(ref_ent(w, src, tg, xl[id]));
      if (fl) q[id].delete();
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0);
    #2;
    rst_chk();
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(1, 32'hFFF00093, 3'd0, 5'd1, 1, 0);
    lit("I", {32'b0, i0.out_imm}, 64'hFFFFFFFF);
    step(1, 32'hFE112E23, 3'd1, 5'd2, 1, 0);
    lit("S", {32'b0, i0.out_imm}, 64'hFFFFFFFC);
    step(1, 32'hFF9FF06F, 3'd3, 5'd3, 1, 0);
    lit("J", {32'b0, i0.out_imm}, 64'hFFFFFFF8);
    step(1, 32'h123450B7, 3'd4, 5'd4, 1, 0);
    lit("U", {32'b0, i0.out_imm}, 64'h12345000);
    step(1, 32'h800000B7, 3'd4, 5'd5, 1, 0);
    lit("U64", i1.out_imm, 64'hFFFFFFFF80000000);
    lit("U32", {32'b0, i0.out_imm}, 64'h80000000);
    step(1, 32'h000F8000, 3'd5, 5'd6, 1, 0);
    lit("Z", {32'b0, i0.out_imm}, 64'h1F);
    step(1, 32'h03F00000, 3'd6, 5'd7, 1, 0);
    lit("SH64", i1.out_imm, 64'h3F);
    lit("SH32", {32'b0, i0.out_imm}, 64'h1F);
    step(1, 32'hFFFFFFFF, 3'd7, 5'd8, 1, 0);
    lit("ILL.imm", {32'b0, i0.out_imm}, 64'h0);
    lit("ILL.flag", {63'b0, i0.out_illegal}, 64'h1);

    step(0, 32'h0, 3'd0, 5'd0, 1, 0);
    step(1, 32'h00100093, 3'd0, 5'd1, 0, 0);
    step(1, 32'h00200093, 3'd0, 5'd2, 0, 0);
    lit("bp.tag1", {59'b0, i0.out_tag}, 64'd1);
    lit("bp.k_full", {63'b0, i0.in_ready}, 64'd0);
    lit("bp.s0_rdy", {63'b0, i2.in_ready}, 64'd0);
    step(1, 32'h00300093, 3'd0, 5'd3, 0, 0);
    lit("bp.hold", {59'b0, i0.out_tag}, 64'd1);
    step(1, 32'h00300093, 3'd0, 5'd3, 1, 0);
    lit("bp.tag2", {59'b0, i0.out_tag}, 64'd2);
    step(1, 32'h00300093, 3'd0, 5'd3, 1, 0);
    lit("bp.tag3", {59'b0, i0.out_tag}, 64'd3);
    step(0, 32'h0, 3'd0, 5'd0, 1, 0);
    step(0, 32'h0, 3'd0, 5'd0, 1, 0);

    step(1, 32'h00400093, 3'd0, 5'd4, 0, 0);
    step(1, 32'h00500093, 3'd0, 5'd5, 0, 0);
    step(1, 32'h00600093, 3'd0, 5'd6, 0, 1);
    lit("fl.valid", {63'b0, i0.out_valid}, 64'd0);
    lit("fl.ready", {63'b0, i0.in_ready}, 64'd1);
    lit("fl.s0_valid", {63'b0, i2.out_valid}, 64'd0);
    step(0, 32'h0, 3'd0, 5'd0, 1, 0);
    step(0, 32'h0, 3'd0, 5'd0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0), $urandom,
           3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
           bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 15) == 0));
    end

    step(1, 32'h00700093, 3'd0, 5'd9, 0, 0);
    step(1, 32'h00800093, 3'd0, 5'd10, 0, 0);
    #1 rst_n = 1'b0;
    #1 rst_chk();
    for (int id = 0; id < 3; id++) q[id].delete();
    #1 rst_n = 1'b1;
    step(1, 32'hFFF00093, 3'd0, 5'd11, 1, 0);
    lit("rst.lat_valid", {63'b0, i0.out_valid}, 64'd1);
    lit("rst.lat_imm", {32'b0, i0.out_imm}, 64'hFFFFFFFF);
    step(0, 32'h0, 3'd0, 5'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
